// File: rtl/riscv_multicycle_control.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback over one shared memory port.
// Outputs are combinational from state and inputs; memory stalls hold the state and trap after MEM_TIMEOUT waits.
module riscv_multicycle_control #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [2:0]       alu_control,
  output logic [3:0]       state,
  output logic             retire,
  output logic             illegal,
  output logic             bus_error,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  cycle_q;
  logic [CNT_W-1:0]  instr_q;
  logic              illegal_q;
  logic              bus_error_q;
  logic              mem_phase;
  logic              waiting;
  logic              timeout;
  logic              set_illegal;

  function automatic logic r_legal(input logic [2:0] f3);
    return f3 inside {3'b000, 3'b010, 3'b101, 3'b110, 3'b111};
  endfunction

  function automatic logic i_legal(input logic [2:0] f3);
    return f3 inside {3'b000, 3'b010, 3'b110, 3'b111};
  endfunction

  function automatic logic [2:0] r_alu(input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  r_alu = f7 ? ALU_SUB : ALU_ADD;
      3'b010:  r_alu = ALU_SLT;
      3'b101:  r_alu = f7 ? ALU_SRA : ALU_SRL;
      3'b110:  r_alu = ALU_OR;
      3'b111:  r_alu = ALU_AND;
      default: r_alu = ALU_ADD;
    endcase
  endfunction

  function automatic logic [2:0] i_alu(input logic [2:0] f3);
    case (f3)
      3'b010:  i_alu = ALU_SLT;
      3'b110:  i_alu = ALU_OR;
      3'b111:  i_alu = ALU_AND;
      default: i_alu = ALU_ADD;
    endcase
  endfunction

  // Derived from state only, so the watchdog never loops back through mem_req.
  assign mem_phase = !reset && (state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE});
  assign waiting   = mem_phase && !mem_ready;
  assign timeout   = waiting && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = ALU_ADD;
    retire      = 1'b0;
    set_illegal = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            state_d    = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          case (opcode)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_RTYPE:          state_d = r_legal(funct3) ? S_EXECR : S_TRAP;
            OP_ITYPE:          state_d = i_legal(funct3) ? S_EXECI : S_TRAP;
            OP_BRANCH:         state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
            OP_JAL:            state_d = S_JAL;
            default:           state_d = S_TRAP;
          endcase
          set_illegal = (state_d == S_TRAP);
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          adr_src = 1'b1;
          if (mem_ready) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWRITE: begin
          adr_src   = 1'b1;
          mem_write = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_EXECR: begin
          alu_src_a   = 2'b10;
          alu_control = r_alu(funct3, funct7_5);
          state_d     = S_ALUWB;
        end
        S_EXECI: begin
          alu_src_a   = 2'b10;
          alu_src_b   = 2'b01;
          alu_control = i_alu(funct3);
          state_d     = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a   = 2'b10;
          alu_control = ALU_SUB;
          pc_write    = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);
          retire      = 1'b1;
          state_d     = S_FETCH;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
          state_d   = S_ALUWB;
        end
        default: state_d = state_q;
      endcase
      // A timeout cycle never has mem_ready, so no write enable is live here.
      if (timeout) state_d = S_TRAP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      wait_cnt    <= '0;
      cycle_q     <= '0;
      instr_q     <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_q + CNT_W'(1);
      if (retire)      instr_q     <= instr_q + CNT_W'(1);
      if (set_illegal) illegal_q   <= 1'b1;
      if (timeout)     bus_error_q <= 1'b1;
      if (waiting && state_d == state_q) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                               wait_cnt <= '0;
    end
  end

  assign mem_req     = mem_phase;
  assign state       = state_q;
  assign illegal     = illegal_q;
  assign bus_error   = bus_error_q;
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Bench for riscv_multicycle_control: directed and random instructions against a per-instruction
// model of expected state sequence, cycle count, write enables and counter totals.
module tb_riscv_multicycle_control;

  localparam int CNT_W = 32;
  localparam int TO    = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [6:0]       opcode = '0;
  logic [2:0]       funct3 = '0;
  logic             funct7_5 = 1'b0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]       alu_src_a, alu_src_b, result_src;
  logic [2:0]       alu_control;
  logic [3:0]       state;
  logic             retire, illegal, bus_error;
  logic [CNT_W-1:0] cycle_count, instr_count;

  int tests = 0;
  int fails = 0;
  int unsigned exp_cyc_total = 0;
  int unsigned exp_ins_total = 0;

  typedef enum int {K_LOAD, K_STORE, K_R, K_I, K_BR, K_JAL, K_ILL} kind_t;

  int          e_cyc, e_ret, e_rw, e_pc, e_ir, e_mw, e_adr, e_trap, e_ill, e_bus, e_alu_chk;
  logic [1:0]  e_src;
  logic [2:0]  e_alu;
  logic [63:0] e_trace;

  always #5 clk = ~clk;

  riscv_multicycle_control #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_control(alu_control), .state(state), .retire(retire), .illegal(illegal),
    .bus_error(bus_error), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] push(input logic [63:0] t, input int s, input int n);
    logic [63:0] r = t;
    for (int i = 0; i < n; i++) r = {r[59:0], 4'(s)};
    return r;
  endfunction

  function automatic kind_t classify(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b0110011: return (f3 inside {3'd0, 3'd2, 3'd5, 3'd6, 3'd7}) ? K_R : K_ILL;
      7'b0010011: return (f3 inside {3'd0, 3'd2, 3'd6, 3'd7}) ? K_I : K_ILL;
      7'b1100011: return (f3 inside {3'd0, 3'd1}) ? K_BR : K_ILL;
      7'b1101111: return K_JAL;
      default:    return K_ILL;
    endcase
  endfunction

  // Expected outcome of one instruction given its fields and the memory wait counts.
  task automatic model(input kind_t k, input logic [2:0] f3, input logic f75, input logic z,
                       input int fw, input int mw);
    int mem_n;
    e_ret = 0; e_rw = 0; e_pc = 0; e_ir = 0; e_mw = 0; e_adr = 0;
    e_trap = 0; e_ill = 0; e_bus = 0; e_src = 2'b00; e_alu = 3'b000; e_alu_chk = 0;
    if (fw >= TO) begin
      e_cyc = TO; e_trap = 1; e_bus = 1; e_trace = push(64'd0, 0, TO);
      return;
    end
    e_ir = 1; e_pc = 1;
    e_trace = push(push(64'd0, 0, fw + 1), 1, 1);
    e_cyc = fw + 2;
    mem_n = (mw >= TO) ? TO : mw + 1;
    case (k)
      K_LOAD, K_STORE: begin
        e_trace = push(push(e_trace, 2, 1), (k == K_LOAD) ? 3 : 5, mem_n);
        e_cyc += 1 + mem_n;
        e_adr = mem_n;
        if (k == K_STORE) e_mw = mem_n;
        if (mw >= TO) begin
          e_trap = 1; e_bus = 1;
        end else if (k == K_LOAD) begin
          e_trace = push(e_trace, 4, 1); e_cyc += 1; e_rw = 1; e_src = 2'b01; e_ret = 1;
        end else e_ret = 1;
      end
      K_R, K_I: begin
        e_trace = push(push(e_trace, (k == K_R) ? 6 : 7, 1), 8, 1);
        e_cyc += 2; e_rw = 1; e_ret = 1; e_alu_chk = 1;
        case (f3)
          3'd0: e_alu = (k == K_R && f75) ? 3'b001 : 3'b000;
          3'd2: e_alu = 3'b101;
          3'd5: e_alu = f75 ? 3'b111 : 3'b110;
          3'd6: e_alu = 3'b011;
          default: e_alu = 3'b010;
        endcase
      end
      K_BR: begin
        e_trace = push(e_trace, 9, 1);
        e_cyc += 1; e_ret = 1; e_alu_chk = 1; e_alu = 3'b001;
        if ((f3 == 3'd0 && z) || (f3 == 3'd1 && !z)) e_pc++;
      end
      K_JAL: begin
        e_trace = push(push(e_trace, 10, 1), 8, 1);
        e_cyc += 2; e_rw = 1; e_ret = 1; e_pc = 2; e_alu_chk = 1;
      end
      default: begin
        e_trap = 1; e_ill = 1;
      end
    endcase
  endtask

  // Called and returns aligned to a falling edge.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                           input logic z, input int fw, input int mw);
    int waited = 0, n = 0, n_ret = 0, n_rw = 0, n_pc = 0, n_ir = 0, n_mw = 0, n_adr = 0;
    int budget = 0;
    bit fetched = 0, trapped = 0, done = 0;
    logic [1:0]  src = 2'b00;
    logic [2:0]  alu = 3'b000;
    logic [63:0] trace = 64'd0;
    model(classify(op, f3), f3, f75, z, fw, mw);
    opcode = op; funct3 = f3; funct7_5 = f75; zero = z;
    while (!done) begin
      #1;
      mem_ready = mem_req ? (waited >= (fetched ? mw : fw)) : 1'($urandom_range(0, 1));
      #1;
      if (budget == 0) begin
        check("start_state", state, 4'd0);
        check("start_cycles", cycle_count, exp_cyc_total);
        check("start_instrs", instr_count, exp_ins_total);
        check("start_flags", {illegal, bus_error}, 2'b00);
      end
      if (state == 4'd11) begin
        trapped = 1; done = 1;
      end else begin
        n++;
        trace = {trace[59:0], state};
        n_ret += int'(retire); n_rw += int'(reg_write); n_pc += int'(pc_write);
        n_ir += int'(ir_write); n_mw += int'(mem_write);
        if (mem_req && adr_src) n_adr++;
        if (reg_write) src = result_src;
        if (state inside {4'd6, 4'd7, 4'd9, 4'd10}) alu = alu_control;
        if (mem_req) begin
          if (mem_ready) waited = 0;
          else waited++;
        end
        if (ir_write) fetched = 1;
        if (retire) done = 1;
      end
      budget++;
      if (budget > 200) begin
        check("cycle_budget", n, e_cyc);
        done = 1;
      end
      @(negedge clk);
    end
    check("cycles", n, e_cyc);
    check("trace", trace, e_trace);
    check("retire_cnt", n_ret, e_ret);
    check("reg_write_cnt", n_rw, e_rw);
    check("pc_write_cnt", n_pc, e_pc);
    check("ir_write_cnt", n_ir, e_ir);
    check("mem_write_cnt", n_mw, e_mw);
    check("adr_alu_cnt", n_adr, e_adr);
    check("trapped", trapped, e_trap);
    check("illegal", illegal, e_ill);
    check("bus_error", bus_error, e_bus);
    if (e_rw != 0) check("wb_src", src, e_src);
    if (e_alu_chk != 0) check("alu_ctl", alu, e_alu);
    exp_cyc_total += e_cyc + ((e_trap != 0) ? 1 : 0);
    exp_ins_total += e_ret;
  endtask

  task automatic trap_hold(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      #1;
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      check("trap_state", {state, mem_req, ir_write, pc_write, reg_write, retire}, {4'd11, 5'b0});
      check("trap_cycles", cycle_count, exp_cyc_total);
      exp_cyc_total++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #2;
      check("rst_ctl", {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, alu_src_a,
                        alu_src_b, result_src, alu_control, retire}, 64'd0);
      check("rst_regs", {state, illegal, bus_error}, 64'd0);
      check("rst_counts", {cycle_count, instr_count}, 64'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    exp_cyc_total = 0;
    exp_ins_total = 0;
  endtask

  initial begin
    logic [6:0] rop;
    do_reset();
    run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0);   // add
    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 3, 3);   // lw, 3 waits on each access
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b1, 0, 0);   // beq taken
    run_instr(7'b1100011, 3'd1, 1'b0, 1'b1, 0, 0);   // bne not taken
    run_instr(7'b1100011, 3'd1, 1'b0, 1'b0, 0, 0);   // bne taken
    run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 0, 2);   // sw
    run_instr(7'b1101111, 3'd0, 1'b0, 1'b0, 1, 0);   // jal
    run_instr(7'b0110011, 3'd0, 1'b1, 1'b0, 0, 0);   // sub
    run_instr(7'b0110011, 3'd5, 1'b1, 1'b0, 0, 0);   // sra
    run_instr(7'b0010011, 3'd0, 1'b1, 1'b0, 0, 0);   // addi ignores funct7_5
    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 15, 15); // longest waits that still complete
    run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0);   // illegal opcode
    trap_hold(3);
    do_reset();
    run_instr(7'b0110011, 3'd1, 1'b0, 1'b0, 0, 0);   // R-type with illegal funct3
    trap_hold(1);
    do_reset();
    run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, TO, 0);  // fetch timeout
    trap_hold(2);
    do_reset();
    run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 0, 1000); // store timeout
    trap_hold(2);
    do_reset();
    opcode = 7'b0000011; mem_ready = 1'b1;            // abort a load mid-flight
    repeat (3) @(negedge clk);
    do_reset();
    run_instr(7'b0010011, 3'd6, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0: rop = 7'b0000011;
        1: rop = 7'b0100011;
        2: rop = 7'b0110011;
        3: rop = 7'b0010011;
        4: rop = 7'b1100011;
        5: rop = 7'b1101111;
        6: rop = 7'b0110011;
        default: rop = 7'($urandom);
      endcase
      run_instr(rop, 3'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      if (e_trap != 0) begin
        trap_hold(1);
        do_reset();
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
